// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Display stage for the 8-bit ALU board. Scans a 4-digit multiplexed,
//   common-anode 7-segment display:
//     DIG1 = state letter, DIG2 = C/V/Z flag glyph, DIG3/DIG4 = result byte in hex.
//   A load strobe captures a snapshot into a shadow register. The snapshot
//   reaches the display register only at a frame boundary, so one scan never
//   mixes old and new data.
//
// Ports
//   gclk      in   1  board clock, all logic on posedge
//   rst       in   1  synchronous active-high reset
//   load      in   1  1-cycle strobe, captures val/state_nr/flags
//   val       in   8  result byte
//   state_nr  in   3  state code 0..6, 7 = blank
//   flags     in   3  {C,V,Z}
//   seg       out  7  segments {a..g} = seg[6:0], active low, registered
//   dig       out  4  digit enables, active low, dig[0] = DIG1, registered
//   frame     out  1  1-cycle pulse after each frame-boundary commit
//   pending   out  1  a captured snapshot waits for commit
module seg7_scan_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD        = 64,
    parameter int LZB         = 1
) (
    input  logic       gclk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] val,
    input  logic [2:0] state_nr,
    input  logic [2:0] flags,
    output logic [6:0] seg,
    output logic [3:0] dig,
    output logic       frame,
    output logic       pending
);

    localparam logic [15:0] TICK_CNT = 16'(REFRESH_DIV - 1);
    localparam logic [15:0] DEAD_CNT = 16'(DEAD);

    logic [15:0] cnt_r;
    logic [1:0]  idx_r;
    logic [7:0]  sh_val_r;
    logic [2:0]  sh_state_r;
    logic [2:0]  sh_flags_r;
    logic [7:0]  dp_val_r;
    logic [2:0]  dp_state_r;
    logic [2:0]  dp_flags_r;
    logic        pending_r;
    logic        frame_r;
    logic [6:0]  seg_r;
    logic [3:0]  dig_r;

    logic        tick_s;
    logic        boundary_s;
    logic [6:0]  seg_s;
    logic [3:0]  dig_s;

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b0000001;
            4'h1:    g = 7'b1001111;
            4'h2:    g = 7'b0010010;
            4'h3:    g = 7'b0000110;
            4'h4:    g = 7'b1001100;
            4'h5:    g = 7'b0100100;
            4'h6:    g = 7'b0100000;
            4'h7:    g = 7'b0001111;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0000100;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b1100000;
            4'hC:    g = 7'b0110001;
            4'hD:    g = 7'b1000010;
            4'hE:    g = 7'b0110000;
            4'hF:    g = 7'b0111000;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    function automatic logic [6:0] state_glyph(input logic [2:0] st);
        logic [6:0] g;
        case (st)
            3'd0:    g = 7'b0001000;  // A
            3'd1:    g = 7'b1100000;  // b
            3'd2:    g = 7'b0000001;  // O
            3'd3:    g = 7'b1110110;  // =
            3'd4:    g = 7'b0110001;  // C
            3'd5:    g = 7'b1100010;  // o
            3'd6:    g = 7'b0010010;  // Z
            default: g = 7'b1111111;  // blank
        endcase
        return g;
    endfunction

    // Segment a = carry, g = overflow, d = zero; active low so a set flag clears its bit.
    function automatic logic [6:0] flag_glyph(input logic [2:0] fl);
        return {~fl[2], 1'b1, 1'b1, ~fl[0], 1'b1, 1'b1, ~fl[1]};
    endfunction

    // Slot tick, frame boundary and next segment/digit pattern from current scan position.
    always_comb begin
        tick_s     = (cnt_r == TICK_CNT);
        boundary_s = tick_s && (idx_r == 2'd3);
        seg_s      = 7'h7F;
        dig_s      = 4'hF;
        if (cnt_r < DEAD_CNT) begin
            seg_s = 7'h7F;
            dig_s = 4'hF;
        end else begin
            dig_s = ~(4'b0001 << idx_r);
            case (idx_r)
                2'd0: seg_s = state_glyph(dp_state_r);
                2'd1: seg_s = flag_glyph(dp_flags_r);
                2'd2: begin
                    if ((LZB != 0) && (dp_val_r[7:4] == 4'h0)) begin
                        seg_s = 7'h7F;
                    end else begin
                        seg_s = hex_glyph(dp_val_r[7:4]);
                    end
                end
                2'd3:    seg_s = hex_glyph(dp_val_r[3:0]);
                default: seg_s = 7'h7F;
            endcase
        end
    end

    // Prescaler and digit index.
    always_ff @(posedge gclk) begin
        if (rst) begin
            cnt_r <= 16'd0;
            idx_r <= 2'd0;
        end else if (tick_s) begin
            cnt_r <= 16'd0;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + 16'd1;
        end
    end

    // Snapshot capture and frame-boundary commit; a load on the boundary bypasses the shadow.
    always_ff @(posedge gclk) begin
        if (rst) begin
            sh_val_r   <= 8'd0;
            sh_state_r <= 3'd7;
            sh_flags_r <= 3'd0;
            dp_val_r   <= 8'd0;
            dp_state_r <= 3'd7;
            dp_flags_r <= 3'd0;
            pending_r  <= 1'b0;
        end else if (boundary_s) begin
            if (load) begin
                dp_val_r   <= val;
                dp_state_r <= state_nr;
                dp_flags_r <= flags;
            end else if (pending_r) begin
                dp_val_r   <= sh_val_r;
                dp_state_r <= sh_state_r;
                dp_flags_r <= sh_flags_r;
            end else begin
                dp_val_r   <= dp_val_r;
                dp_state_r <= dp_state_r;
                dp_flags_r <= dp_flags_r;
            end
            pending_r <= 1'b0;
        end else if (load) begin
            sh_val_r   <= val;
            sh_state_r <= state_nr;
            sh_flags_r <= flags;
            pending_r  <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Output registers.
    always_ff @(posedge gclk) begin
        if (rst) begin
            seg_r   <= 7'h7F;
            dig_r   <= 4'hF;
            frame_r <= 1'b0;
        end else begin
            seg_r   <= seg_s;
            dig_r   <= dig_s;
            frame_r <= boundary_s;
        end
    end

    assign seg     = seg_r;
    assign dig     = dig_r;
    assign frame   = frame_r;
    assign pending = pending_r;

endmodule
